// File: rtl/spio_merge.sv
// spio_merge: round-robin fan-in of NUM_PORTS valid/ready packet streams into
// a single output stream through one registered output stage (one cycle
// latency, one packet per cycle when the output is always ready).
//
// Ports:
//   CLK_IN             in   clock
//   RESET_IN           in   synchronous, active-high reset
//   IN_DATA_IN         in   port i packet at [i*PKT_BITS +: PKT_BITS]
//   IN_VLD_IN          in   per-port valid
//   IN_RDY_OUT         out  per-port ready (at most one bit set)
//   OUT_DATA_OUT       out  merged packet
//   OUT_VLD_OUT        out  output valid
//   OUT_RDY_IN         in   output ready
//   OUT_SOURCE_OUT     out  one-hot origin of OUT_DATA_OUT
//   WAITING_INPUTS_OUT out  ports presenting a packet that is not being taken
module spio_merge #(
  parameter int PKT_BITS  = 72,
  parameter int NUM_PORTS = 4
) (
  input  logic                          CLK_IN,
  input  logic                          RESET_IN,
  input  logic [NUM_PORTS*PKT_BITS-1:0] IN_DATA_IN,
  input  logic [NUM_PORTS-1:0]          IN_VLD_IN,
  output logic [NUM_PORTS-1:0]          IN_RDY_OUT,
  output logic [PKT_BITS-1:0]           OUT_DATA_OUT,
  output logic                          OUT_VLD_OUT,
  input  logic                          OUT_RDY_IN,
  output logic [NUM_PORTS-1:0]          OUT_SOURCE_OUT,
  output logic [NUM_PORTS-1:0]          WAITING_INPUTS_OUT
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  // Output register and arbiter history
  logic [PKT_BITS-1:0]  data_p1;
  logic [NUM_PORTS-1:0] src_p1;
  logic                 vld_p1;
  logic [IDX_W-1:0]     last_p1;

  // Arbitration (combinational, stage 0)
  logic                 free_p0;
  logic                 accept_p0;
  logic                 hi_found_p0;
  logic                 lo_found_p0;
  logic [IDX_W-1:0]     hi_idx_p0;
  logic [IDX_W-1:0]     lo_idx_p0;
  logic [IDX_W-1:0]     gnt_idx_p0;
  logic [NUM_PORTS-1:0] gnt_oh_p0;
  logic [PKT_BITS-1:0]  gnt_data_p0;

  // Round-robin search without a variable rotate: the lowest valid port above
  // 'last' wins if there is one, otherwise the lowest valid port overall
  // (the wrap-around case). Scanning downward lets the last hit be the lowest.
  always_comb begin
    hi_found_p0 = 1'b0;
    lo_found_p0 = 1'b0;
    hi_idx_p0   = '0;
    lo_idx_p0   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (IN_VLD_IN[i]) begin
        lo_found_p0 = 1'b1;
        lo_idx_p0   = IDX_W'(i);
        if (IDX_W'(i) > last_p1) begin
          hi_found_p0 = 1'b1;
          hi_idx_p0   = IDX_W'(i);
        end
      end
    end
  end

  assign gnt_idx_p0 = hi_found_p0 ? hi_idx_p0 : lo_idx_p0;

  always_comb begin
    gnt_oh_p0   = '0;
    gnt_data_p0 = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (lo_found_p0 && (gnt_idx_p0 == IDX_W'(i))) begin
        gnt_oh_p0[i] = 1'b1;
        gnt_data_p0  = IN_DATA_IN[i*PKT_BITS +: PKT_BITS];
      end
    end
  end

  // The register can take a new packet when empty or when its current packet
  // leaves this same cycle.
  assign free_p0   = !vld_p1 || OUT_RDY_IN;
  assign accept_p0 = free_p0 && lo_found_p0 && !RESET_IN;

  assign IN_RDY_OUT         = accept_p0 ? gnt_oh_p0 : '0;
  assign WAITING_INPUTS_OUT = IN_VLD_IN & ~IN_RDY_OUT;

  // Stage 0 -> stage 1: output register
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      src_p1  <= '0;
      last_p1 <= IDX_W'(NUM_PORTS - 1);
    end else if (free_p0) begin
      if (accept_p0) begin
        vld_p1  <= 1'b1;
        data_p1 <= gnt_data_p0;
        src_p1  <= gnt_oh_p0;
        last_p1 <= gnt_idx_p0;
      end else begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign OUT_DATA_OUT   = data_p1;
  assign OUT_VLD_OUT    = vld_p1;
  assign OUT_SOURCE_OUT = src_p1;

endmodule
